// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter serialising accesses onto one single-port synchronous RAM.
// Define RAM_RR_ARBITER_STATS_EN to add saturating per-requester grant counters GCNT_A/GCNT_B.
module ram_rr_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RAM_SIZE = 3072
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_A,
    input  logic              REQ_B,
    input  logic              WE_A,
    input  logic              WE_B,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] WDATA_A,
    input  logic [DATA_W-1:0] WDATA_B,
    output logic              GNT_A,
    output logic              GNT_B,
    output logic              RVALID_A,
    output logic              RVALID_B,
    output logic [DATA_W-1:0] RDATA_A,
    output logic [DATA_W-1:0] RDATA_B,
    output logic              ERR_A,
    output logic              ERR_B,
    output logic              RAM_RDEN,
    output logic              RAM_WREN,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_IN_DATA,
`ifdef RAM_RR_ARBITER_STATS_EN
    output logic [15:0]       GCNT_A,
    output logic [15:0]       GCNT_B,
`endif
    input  logic [DATA_W-1:0] RAM_OUT_DATA
);

    logic              last_b_q;
    logic              rvalid_a_q;
    logic              rvalid_b_q;
    logic              err_a_q;
    logic              err_b_q;
    logic              rd_oor_q;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] wdata_hold_q;

    logic              gnt_a;
    logic              gnt_b;
    logic              gnt_any;
    logic              sel_we;
    logic              sel_in_range;
    logic              ram_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Grants are masked by reset so nothing can transfer while RST_N is low.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (RST_N) begin
            if (REQ_A && REQ_B) begin
                gnt_a = last_b_q;
                gnt_b = ~last_b_q;
            end else begin
                gnt_a = REQ_A;
                gnt_b = REQ_B;
            end
        end
    end

    assign gnt_any      = gnt_a | gnt_b;
    assign sel_we       = gnt_b ? WE_B    : WE_A;
    assign sel_addr     = gnt_b ? ADDR_B  : ADDR_A;
    assign sel_wdata    = gnt_b ? WDATA_B : WDATA_A;
    assign sel_in_range = 32'(sel_addr) < RAM_SIZE;
    assign ram_en       = gnt_any & sel_in_range;

    assign GNT_A       = gnt_a;
    assign GNT_B       = gnt_b;
    assign RAM_WREN    = ram_en & sel_we;
    assign RAM_RDEN    = ram_en & ~sel_we;
    assign RAM_ADDR    = ram_en ? sel_addr  : addr_hold_q;
    assign RAM_IN_DATA = ram_en ? sel_wdata : wdata_hold_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_b_q     <= 1'b1;
            rvalid_a_q   <= 1'b0;
            rvalid_b_q   <= 1'b0;
            err_a_q      <= 1'b0;
            err_b_q      <= 1'b0;
            rd_oor_q     <= 1'b0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            rvalid_a_q <= gnt_a & ~sel_we;
            rvalid_b_q <= gnt_b & ~sel_we;
            err_a_q    <= gnt_a & ~sel_in_range;
            err_b_q    <= gnt_b & ~sel_in_range;
            rd_oor_q   <= ~sel_in_range;
            if (gnt_any) begin
                last_b_q <= gnt_b;
            end
            if (ram_en) begin
                addr_hold_q  <= sel_addr;
                wdata_hold_q <= sel_wdata;
            end
        end
    end

    // Out-of-range reads return zero instead of whatever the RAM last produced.
    assign RVALID_A = rvalid_a_q;
    assign RVALID_B = rvalid_b_q;
    assign RDATA_A  = (rvalid_a_q && !rd_oor_q) ? RAM_OUT_DATA : '0;
    assign RDATA_B  = (rvalid_b_q && !rd_oor_q) ? RAM_OUT_DATA : '0;
    assign ERR_A    = err_a_q;
    assign ERR_B    = err_b_q;

`ifdef RAM_RR_ARBITER_STATS_EN
    logic [15:0] gcnt_a_q;
    logic [15:0] gcnt_b_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gcnt_a_q <= '0;
            gcnt_b_q <= '0;
        end else begin
            if (gnt_a && (gcnt_a_q != 16'hFFFF)) begin
                gcnt_a_q <= gcnt_a_q + 16'd1;
            end
            if (gnt_b && (gcnt_b_q != 16'hFFFF)) begin
                gcnt_b_q <= gcnt_b_q + 16'd1;
            end
        end
    end

    assign GCNT_A = gcnt_a_q;
    assign GCNT_B = gcnt_b_q;
`endif

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Two-requester round-robin arbiter in front of one single-port synchronous RAM (RDEN/WREN/ADDR/IN_DATA in, registered OUT_DATA out, 1-cycle read latency, write has priority inside the RAM).
- Serialises requester accesses onto the RAM and routes read data back with a valid strobe.
- Rejects out-of-range addresses without touching the RAM.

Parameters:
- ADDR_W, 12, address width, shared by requesters and RAM.
- DATA_W, 16, data width.
- RAM_SIZE, 3072, number of valid RAM words; addresses >= RAM_SIZE are out of range.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_A, REQ_B  in  1  access request per requester.
- WE_A, WE_B  in  1  1 = write, 0 = read; qualified by REQ_x.
- ADDR_A, ADDR_B  in  ADDR_W  access address.
- WDATA_A, WDATA_B  in  DATA_W  write data.
- GNT_A, GNT_B  out  1  request accepted this cycle (combinational).
- RVALID_A, RVALID_B  out  1  read data valid (registered).
- RDATA_A, RDATA_B  out  DATA_W  read data; valid only while RVALID_x = 1.
- ERR_A, ERR_B  out  1  one-cycle pulse: out-of-range access completed.
- RAM_RDEN, RAM_WREN  out  1  RAM enables.
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_IN_DATA  out  DATA_W  RAM write data.
- RAM_OUT_DATA  in  DATA_W  RAM registered read data.

Behaviour:
- Reset, asynchronous, while RST_N = 0:
  - RVALID_x = 0, ERR_x = 0, RDATA_x = 0.
  - LAST pointer = B, so A wins the first contention.
  - Read-tag register cleared.
  - GNT_x, RAM_RDEN and RAM_WREN forced to 0 combinationally.
- Handshake:
  - Requester holds REQ_x, WE_x, ADDR_x and WDATA_x stable until it sees GNT_x = 1 at a rising edge.
  - Transfer occurs on that edge.
  - Requester may drop or change the request on the next cycle.
- Arbitration, combinational, each cycle:
  - Only one requesting: it is granted.
  - Both requesting: grant the one != LAST.
  - On every edge with a grant, LAST <= granted requester.
  - A lone requester is granted every cycle: back-to-back throughput 1 access per cycle.
- RAM drive, in a granted cycle with an in-range address:
  - RAM_ADDR = ADDR_x.
  - RAM_IN_DATA = WDATA_x.
  - RAM_WREN = WE_x.
  - RAM_RDEN = ~WE_x.
  - No grant: both enables 0; RAM_ADDR and RAM_IN_DATA hold the last values (don't-care).
- Read return:
  - Read granted at edge N: tag register stores the requester.
  - In cycle N+1: RVALID_x = 1 and RDATA_x = RAM_OUT_DATA.
  - The other requester's RDATA is 0.
  - Latency from grant edge to data valid is exactly 1 cycle.
  - A new grant in cycle N+1 does not disturb that return.
- Write: completes at the grant edge; no response strobe.
- Out of range (ADDR_x >= RAM_SIZE):
  - Granted normally and LAST updated.
  - RAM enables stay 0.
  - ERR_x pulses in cycle N+1.
  - A read also gives RVALID_x = 1 with RDATA_x = 0.
- Ordering: accesses execute in grant order. A write from A granted before a read from B at the same address makes B read the new data.
- Reset mid-operation: a pending read return is dropped (no RVALID after reset release). The first grant is only possible in the first cycle with RST_N = 1.

Optional Feature:
- Macro: RAM_RR_ARBITER_STATS_EN.
- Defined:
  - Adds outputs GCNT_A and GCNT_B (16 bits each).
  - Each counts completed grants (in-range and out-of-range).
  - Saturates at 0xFFFF; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then A writes 0x1234 to address 5 (1 cycle), then A reads address 5 -> GNT_A each cycle; RVALID_A = 1 with RDATA_A = 0x1234 one cycle after the read grant.
- REQ_A and REQ_B held for 4 cycles from reset, both reads -> grants A, B, A, B; each RVALID one cycle after the matching grant; other requester's RVALID = 0.
- A writes 0xBEEF to address 100 while B reads address 100 in the same cycle, after reset -> A granted first, B next cycle; RDATA_B = 0xBEEF.
- B reads address 3072 -> GNT_B = 1, RAM_RDEN stays 0, next cycle ERR_B = 1, RVALID_B = 1, RDATA_B = 0.
- Read granted, then RST_N pulsed low for half a cycle before the next edge -> RVALID_A never asserts; after release both requesting -> A granted first.
- With RAM_RR_ARBITER_STATS_EN: 70000 back-to-back A grants -> GCNT_A = 0xFFFF, GCNT_B = 0.
